// File: rtl/sa_pkg.sv
// Shared types and arithmetic helpers for the sa_matmul_core systolic engine.
// SA_SATURATE_EN adds the clamping accumulate helper.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } sa_state_e;

    // Widest accumulator the saturating helper can handle.
    localparam int unsigned SA_MAX_W = 64;

    function automatic int unsigned sa_prod_w(input int unsigned data_w);
        return 2 * data_w;
    endfunction

`ifdef SA_SATURATE_EN
    // Add two sign-extended operands and clamp to the signed w-bit range.
    function automatic logic signed [SA_MAX_W-1:0] sa_sat_add(
        input logic signed [SA_MAX_W-1:0] a,
        input logic signed [SA_MAX_W-1:0] b,
        input int unsigned                w
    );
        logic signed [SA_MAX_W:0] sum;
        logic signed [SA_MAX_W:0] hi;
        logic signed [SA_MAX_W:0] lo;
        sum = {a[SA_MAX_W-1], a} + {b[SA_MAX_W-1], b};
        lo  = '1;
        lo  = lo << (w - 1);
        hi  = ~lo;
        if (sum > hi) begin
            return hi[SA_MAX_W-1:0];
        end
        if (sum < lo) begin
            return lo[SA_MAX_W-1:0];
        end
        return sum[SA_MAX_W-1:0];
    endfunction
`endif

endpackage

// File: rtl/sa_matmul_core_pe.sv
// One signed MAC processing element: registers activation right, weight down.
// SA_SATURATE_EN selects a clamping accumulate instead of wrap-around.
module sa_pe
    import sa_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] w_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] w_out,
    output logic [ACC_W-1:0]  acc
);

    localparam int unsigned PROD_W = sa_prod_w(DATA_W);

    logic [DATA_W-1:0]        a_q, a_d;
    logic [DATA_W-1:0]        w_q, w_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    always_comb begin
        prod     = PROD_W'($signed(a_in)) * PROD_W'($signed(w_in));
        prod_ext = ACC_W'(prod);
        a_d      = a_q;
        w_d      = w_q;
        acc_d    = acc_q;
        if (clr) begin
            a_d   = '0;
            w_d   = '0;
            acc_d = '0;
        end else if (en) begin
            a_d = a_in;
            w_d = w_in;
`ifdef SA_SATURATE_EN
            acc_d = ACC_W'(sa_sat_add(SA_MAX_W'($signed(acc_q)), SA_MAX_W'(prod_ext), ACC_W));
`else
            acc_d = acc_q + ACC_W'(prod_ext);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            w_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            w_q   <= w_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign w_out = w_q;
    assign acc   = acc_q;

endmodule

// File: rtl/sa_matmul_core.sv
// Output-stationary ROWS x COLS systolic matmul with internal input skew and a
// row-major valid/ready result drain. SA_SATURATE_EN enables clamping accumulation.
module sa_matmul_core
    import sa_pkg::*;
#(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned K_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   act_data,
    input  logic [COLS*DATA_W-1:0]   wgt_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [$clog2(ROWS)-1:0]  out_row,
    output logic [$clog2(COLS)-1:0]  out_col,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned ROW_W     = $clog2(ROWS);
    localparam int unsigned COL_W     = $clog2(COLS);
    localparam int unsigned LANES     = ROWS + COLS;
    localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;
    localparam int unsigned FL_W      = $clog2(FLUSH_LEN + 1);
    localparam int unsigned CNT_W     = (K_W > FL_W) ? K_W : FL_W;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    sa_state_e          state_q, state_d;
    logic [K_W-1:0]     klen_q, klen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               arr_en;
    logic               arr_clr;

    logic [LANES*DATA_W-1:0] lane_all;
    logic [DATA_W-1:0]       sk [LANES];
    logic [DATA_W-1:0]       a_h [ROWS][COLS+1];
    logic [DATA_W-1:0]       w_v [ROWS+1][COLS];
    logic [ACC_W-1:0]        acc_w [ROWS][COLS];
    logic [ROWS-1:0]         unused_a_edge;
    logic [COLS-1:0]         unused_w_edge;

    // Global step: accepted beat in FEED, or every cycle while flushing.
    assign arr_en   = ((state_q == FEED) && in_valid) || (state_q == FLUSH);
    assign lane_all = (state_q == FEED) ? {wgt_data, act_data} : '0;

    // Lanes 0..ROWS-1 are activations (delay r); the rest are weights (delay c).
    for (genvar l = 0; l < LANES; l++) begin : g_skew
        localparam int unsigned D = (l < ROWS) ? l : l - ROWS;
        if (D == 0) begin : g_direct
            assign sk[l] = lane_all[l*DATA_W +: DATA_W];
        end else begin : g_delay
            logic [DATA_W-1:0] sr_q [D];
            logic [DATA_W-1:0] sr_d [D];
            always_comb begin
                sr_d = sr_q;
                if (arr_clr) begin
                    sr_d = '{default: '0};
                end else if (arr_en) begin
                    sr_d[0] = lane_all[l*DATA_W +: DATA_W];
                    for (int i = 1; i < D; i++) begin
                        sr_d[i] = sr_q[i-1];
                    end
                end
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sr_q <= '{default: '0};
                end else begin
                    sr_q <= sr_d;
                end
            end
            assign sk[l] = sr_q[D-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign a_h[r][0]        = sk[r];
        assign unused_a_edge[r] = ^a_h[r][COLS];
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sa_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .en    (arr_en),
                .clr   (arr_clr),
                .a_in  (a_h[r][c]),
                .w_in  (w_v[r][c]),
                .a_out (a_h[r][c+1]),
                .w_out (w_v[r+1][c]),
                .acc   (acc_w[r][c])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wtop
        assign w_v[0][c]        = sk[ROWS+c];
        assign unused_w_edge[c] = ^w_v[ROWS][c];
    end

    always_comb begin
        state_d     = state_q;
        klen_d      = klen_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        arr_clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    arr_clr    = 1'b1;
                    klen_d     = k_len;
                    cnt_d      = '0;
                    row_d      = '0;
                    col_d      = '0;
                    out_data_d = '0;
                    out_last_d = 1'b0;
                    if (k_len == '0) begin
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (in_valid) begin
                    if (cnt_q == CNT_W'(klen_q) - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                    // PE(0,0) finished long before the last flush step.
                    cnt_d       = '0;
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_w[0][0];
                    out_last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        row_d       = '0;
                        col_d       = '0;
                        done_d      = 1'b1;
                    end else begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                        out_data_d = acc_w[row_d][col_d];
                        out_last_d = (row_d == ROW_LAST) && (col_d == COL_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == FEED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            klen_q      <= '0;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            klen_q      <= klen_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sa_matmul_core.sv
// Directed self-checking bench for sa_matmul_core on a 2x2 grid, 8-bit data,
// 16-bit accumulators; expectations follow SA_SATURATE_EN when defined.
module tb_sa_matmul_core;

    localparam int unsigned ROWS   = 2;
    localparam int unsigned COLS   = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned K_W    = 8;

`ifdef SA_SATURATE_EN
    localparam longint OVF = 32767;
`else
    localparam longint OVF = -32768;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [K_W-1:0]          k_len = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [ROWS*DATA_W-1:0]  act_data = '0;
    logic [COLS*DATA_W-1:0]  wgt_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [ACC_W-1:0]        out_data;
    logic [0:0]              out_row;
    logic [0:0]              out_col;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [15:0] acts [4];
    logic [15:0] wgts [4];
    longint      exp_c [4];

    sa_matmul_core #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .K_W    (K_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_data  (act_data),
        .wgt_data  (wgt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a matmul, feed klen beats with optional stalls, drain and check.
    task automatic run_mm(input string tag, input int klen, input int stall,
                          input bit bp, input int exp_lat);
        int     s;
        int     n;
        int     budget;
        int     pidx;
        bit     holding;
        bit     first_seen;
        longint held;
        bit     pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        start = 1'b1;
        k_len = K_W'(klen);
        @(negedge clk);
        start = 1'b0;
        k_len = 8'd99;
        s = cyc;
        chk({tag, "_in_ready"}, longint'(in_ready), (klen != 0) ? 1 : 0);
        chk({tag, "_busy"}, longint'(busy), 1);
        for (int b = 0; b < klen; b++) begin
            in_valid = 1'b1;
            act_data = acts[b];
            wgt_data = wgts[b];
            @(negedge clk);
            if (stall > 0 && b < klen - 1) begin
                in_valid = 1'b0;
                repeat (stall) @(negedge clk);
            end
        end
        in_valid   = 1'b0;
        act_data   = '0;
        wgt_data   = '0;
        n          = 0;
        budget     = 0;
        pidx       = 0;
        holding    = 1'b0;
        first_seen = 1'b0;
        held       = 0;
        while (n < 4 && budget < 200) begin
            if (budget > 0 || klen > 0) @(negedge clk);
            budget++;
            if (holding) chk({tag, "_hold"}, longint'($signed(out_data)), held);
            holding   = 1'b0;
            out_ready = bp ? pat[pidx % 4] : 1'b1;
            pidx++;
            if (out_valid) begin
                if (!first_seen && exp_lat >= 0) chk({tag, "_latency"}, longint'(cyc - s), exp_lat);
                first_seen = 1'b1;
                if (out_ready) begin
                    chk({tag, "_data"}, longint'($signed(out_data)), exp_c[n]);
                    chk({tag, "_row"}, longint'(out_row), n / 2);
                    chk({tag, "_col"}, longint'(out_col), n % 2);
                    chk({tag, "_last"}, longint'(out_last), (n == 3) ? 1 : 0);
                    n++;
                end else begin
                    holding = 1'b1;
                    held    = longint'($signed(out_data));
                end
            end
        end
        chk({tag, "_count"}, longint'(n), 4);
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done"}, longint'(done), 1);
        chk({tag, "_busy_end"}, longint'(busy), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, longint'(done), 0);
    endtask

    task automatic load_basic();
        acts  = '{16'h0301, 16'h0402, 16'h0000, 16'h0000};
        wgts  = '{16'h0605, 16'h0807, 16'h0000, 16'h0000};
        exp_c = '{19, 22, 43, 50};
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_done", longint'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        load_basic();
        run_mm("basic", 2, 0, 1'b0, 5);
        run_mm("stall", 2, 3, 1'b0, 8);
        run_mm("bp", 2, 0, 1'b1, 5);

        exp_c = '{0, 0, 0, 0};
        run_mm("klen0", 0, 0, 1'b0, -1);

        acts  = '{16'h8080, 16'h8080, 16'h0000, 16'h0000};
        wgts  = '{16'h8080, 16'h8080, 16'h0000, 16'h0000};
        exp_c = '{OVF, OVF, OVF, OVF};
        run_mm("ovf", 2, 0, 1'b0, 5);

        // Abort after one of four beats, then rerun the basic case.
        acts  = '{16'h0909, 16'h0909, 16'h0909, 16'h0909};
        wgts  = '{16'h0909, 16'h0909, 16'h0909, 16'h0909};
        start = 1'b1;
        k_len = 8'd4;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        act_data = acts[0];
        wgt_data = wgts[0];
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_in_ready", longint'(in_ready), 0);
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_done", longint'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_done", longint'(done), 0);
        load_basic();
        run_mm("after_abort", 2, 0, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
